// File: rtl/generador_sensores_auto.sv
// Car emulator for the parking a/b sensor protocol.
// Turns one-shot enter/exit commands into timed, glitch-free a/b waveforms.
module generador_sensores_auto #(
  parameter int unsigned PHASE_CYCLES = 1200000,
  parameter int unsigned GAP_CYCLES   = 1200000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_entrada,
  input  logic cmd_salida,
  input  logic medio,
  output logic a,
  output logic b,
  output logic ocupado,
  output logic sentido,
  output logic fin,
  output logic rechazado
);

  typedef enum logic [2:0] {
    REPOSO,
    FASE1,
    FASE2,
    FASE3,
    PAUSA
  } estado_t;

  localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] UNO      = CNT_W'(1);

  estado_t          state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             sentido_q, sentido_d;
  logic             medio_q, medio_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             ocupado_q, ocupado_d;
  logic             fin_q, fin_d;
  logic             aceptar;

  // exactly one command while idle starts a sequence
  assign aceptar = (state_q == REPOSO) && (cmd_entrada ^ cmd_salida);

  // next state, phase timer and latched command attributes
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + UNO;
    sentido_d = sentido_q;
    medio_d   = medio_q;
    fin_d     = 1'b0;
    unique case (state_q)
      REPOSO: begin
        timer_d = '0;
        if (aceptar) begin
          state_d   = FASE1;
          sentido_d = cmd_entrada;
          medio_d   = medio;
        end
      end
      FASE1: if (timer_q == PH_LAST) state_d = FASE2;
      FASE2: if (timer_q == PH_LAST) state_d = FASE3;
      FASE3: if (timer_q == PH_LAST) state_d = PAUSA;
      PAUSA: begin
        if (timer_q == GAP_LAST) begin
          state_d = REPOSO;
          fin_d   = 1'b1;
        end
      end
      default: state_d = REPOSO;
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  // sensor pattern for the state being entered; half sequences fall back to phase 1
  always_comb begin
    a_d       = 1'b0;
    b_d       = 1'b0;
    ocupado_d = (state_d != REPOSO);
    unique case (state_d)
      FASE1: begin
        a_d = sentido_d;
        b_d = ~sentido_d;
      end
      FASE2: begin
        a_d = 1'b1;
        b_d = 1'b1;
      end
      FASE3: begin
        a_d = medio_d ? sentido_d : ~sentido_d;
        b_d = medio_d ? ~sentido_d : sentido_d;
      end
      default: begin
        a_d = 1'b0;
        b_d = 1'b0;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= REPOSO;
      timer_q   <= '0;
      sentido_q <= 1'b0;
      medio_q   <= 1'b0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      ocupado_q <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sentido_q <= sentido_d;
      medio_q   <= medio_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ocupado_q <= ocupado_d;
      fin_q     <= fin_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign ocupado   = ocupado_q;
  assign sentido   = sentido_q;
  assign fin       = fin_q;
  // flagged in the same cycle as the refused command
  assign rechazado = ~rst & (cmd_entrada | cmd_salida) &
                     (ocupado_q | (cmd_entrada & cmd_salida));

endmodule

// File: tb/tb_generador_sensores_auto.sv
// Bench for generador_sensores_auto.
// Table vectors, directed corners and random commands against a queue model.
module tb_generador_sensores_auto;

  localparam int PH  = 4;
  localparam int GAP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_entrada = 1'b0;
  logic cmd_salida = 1'b0;
  logic medio = 1'b0;
  logic a, b, ocupado, sentido, fin, rechazado;

  int total = 0;
  int fails = 0;

  generador_sensores_auto #(
    .PHASE_CYCLES(PH),
    .GAP_CYCLES(GAP),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_entrada(cmd_entrada),
    .cmd_salida(cmd_salida),
    .medio(medio),
    .a(a),
    .b(b),
    .ocupado(ocupado),
    .sentido(sentido),
    .fin(fin),
    .rechazado(rechazado)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit a, b, ocu, fin;
  } exp_t;

  typedef struct {
    bit e, s, m;
    bit ea, eb, eo, ef, er, es;
  } vec_t;

  exp_t q[$];
  bit   sen_m = 1'b0;
  vec_t tab[17];

  task automatic chk(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0b exp=%0b t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic exp_t mk_e(bit ea, bit eb, bit eo, bit ef);
    exp_t x;
    x.a = ea; x.b = eb; x.ocu = eo; x.fin = ef;
    return x;
  endfunction

  // whole expected waveform of one sequence, cycle by cycle
  task automatic push_seq(input bit dir, input bit med);
    bit fa, fb;
    fa = dir;
    fb = !dir;
    for (int i = 0; i < PH; i++) q.push_back(mk_e(fa, fb, 1, 0));
    for (int i = 0; i < PH; i++) q.push_back(mk_e(1, 1, 1, 0));
    for (int i = 0; i < PH; i++)
      q.push_back(med ? mk_e(fa, fb, 1, 0) : mk_e(fb, fa, 1, 0));
    for (int i = 0; i < GAP; i++) q.push_back(mk_e(0, 0, 1, 0));
    q.push_back(mk_e(0, 0, 0, 1));
  endtask

  task automatic cyc(input bit e, input bit s, input bit m);
    exp_t cur;
    bit   busy, exp_r, acc;
    @(negedge clk);
    cmd_entrada = e;
    cmd_salida  = s;
    medio       = m;
    #1;
    cur   = (q.size() != 0) ? q[0] : mk_e(0, 0, 0, 0);
    busy  = cur.ocu;
    exp_r = (e | s) & (busy | (e & s));
    acc   = !busy & (e ^ s);
    chk("a", a, cur.a);
    chk("b", b, cur.b);
    chk("ocupado", ocupado, cur.ocu);
    chk("fin", fin, cur.fin);
    chk("rechazado", rechazado, exp_r);
    chk("sentido", sentido, sen_m);
    if (q.size() != 0) void'(q.pop_front());
    if (acc) begin
      sen_m = e;
      push_seq(e, m);
    end
  endtask

  function automatic vec_t mk_v(bit e, bit s, bit m, bit ea, bit eb,
                                bit eo, bit ef, bit er, bit es);
    vec_t v;
    v.e = e; v.s = s; v.m = m;
    v.ea = ea; v.eb = eb; v.eo = eo; v.ef = ef; v.er = er; v.es = es;
    return v;
  endfunction

  initial begin
    int r;
    tab[0] = mk_v(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) tab[i] = mk_v(0, 0, 0, 1, 0, 1, 0, 0, 1);
    tab[3] = mk_v(0, 1, 0, 1, 0, 1, 0, 1, 1);
    for (int i = 5; i <= 8; i++) tab[i] = mk_v(0, 0, 0, 1, 1, 1, 0, 0, 1);
    for (int i = 9; i <= 12; i++) tab[i] = mk_v(0, 0, 0, 0, 1, 1, 0, 0, 1);
    tab[13] = mk_v(0, 0, 0, 0, 0, 1, 0, 0, 1);
    tab[14] = mk_v(0, 0, 0, 0, 0, 1, 0, 0, 1);
    tab[15] = mk_v(1, 0, 1, 0, 0, 0, 1, 0, 1);
    tab[16] = mk_v(0, 0, 0, 1, 0, 1, 0, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_a", a, 1'b0);
    chk("rst_b", b, 1'b0);
    chk("rst_ocupado", ocupado, 1'b0);
    chk("rst_fin", fin, 1'b0);
    chk("rst_sentido", sentido, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      cyc(tab[i].e, tab[i].s, tab[i].m);
      chk($sformatf("tab%0d_a", i), a, tab[i].ea);
      chk($sformatf("tab%0d_b", i), b, tab[i].eb);
      chk($sformatf("tab%0d_ocu", i), ocupado, tab[i].eo);
      chk($sformatf("tab%0d_fin", i), fin, tab[i].ef);
      chk($sformatf("tab%0d_rech", i), rechazado, tab[i].er);
      chk($sformatf("tab%0d_sen", i), sentido, tab[i].es);
    end

    for (int i = 0; i < 40 && q.size() != 0; i++) cyc(0, 0, 0);
    chk("drain_idle", ocupado, 1'b0);

    cyc(1, 1, 0);
    chk("both_rech", rechazado, 1'b1);
    cyc(0, 0, 0);
    chk("both_stays_idle", ocupado, 1'b0);

    cyc(0, 1, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0);
    cyc(1, 0, 1);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 9));
      cyc(r == 0 || r == 2, r == 1 || r == 2, 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 40 && q.size() != 0; i++) cyc(0, 0, 0);
    cyc(1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0);
    chk("pre_rst_a", a, 1'b1);
    chk("pre_rst_b", b, 1'b1);
    @(negedge clk);
    cmd_entrada = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_a", a, 1'b0);
    chk("arst_b", b, 1'b0);
    chk("arst_ocupado", ocupado, 1'b0);
    chk("arst_sentido", sentido, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    sen_m = 1'b0;
    cyc(1, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/generador_sensores_auto.md
Name: generador_sensores_auto

Overview:
- Car emulator: the encoder for the parking a/b sensor protocol. It turns one-shot "car enters" or "car leaves" commands into timed a/b sensor waveforms.
- Output feeds the entry/exit FSM in place of the debounced BTN1/BTN4 sensors. This supports self-test and demo of the car counter without physical buttons.
- Also produces incomplete "car backs out halfway" sequences, which the FSM must not count.

Parameters:
- PHASE_CYCLES, 1200000, clock cycles each sensor phase is held (100 ms at 12 MHz); must be >= 1.
- GAP_CYCLES, 1200000, cycles a=b=0 is held after a sequence before the next command is accepted; must be >= 1.
- CNT_W, 32, width of the internal phase/gap timer; must hold max(PHASE_CYCLES, GAP_CYCLES).

Ports:
- clk  input  1  system clock (12 MHz board clock).
- rst  input  1  asynchronous, active-high reset.
- cmd_entrada  input  1  request one entering car; sampled every cycle; level is fine, acted on only when idle.
- cmd_salida  input  1  request one exiting car; same rules as cmd_entrada.
- medio  input  1  sampled with the accepted command; 1 = car stops halfway and backs out.
- a  output  1  emulated sensor pair 'a' (1 = obstructed), registered.
- b  output  1  emulated sensor pair 'b' (1 = obstructed), registered.
- ocupado  output  1  sequence in progress, including the gap.
- sentido  output  1  latched direction of the current/last sequence: 1 entry, 0 exit.
- fin  output  1  one-cycle pulse when a sequence (including gap) completes.
- rechazado  output  1  one-cycle pulse when a command is not accepted.

Behaviour:
- Reset (async, immediate, also mid-sequence): a=b=0, ocupado=0, sentido=0, fin=0, rechazado=0, state=REPOSO, timer=0. Operation resumes in REPOSO on the first clk edge after rst deasserts.
- States: REPOSO, FASE1, FASE2, FASE3, PAUSA.
- Command acceptance in REPOSO, cycle k:
  - Exactly one of cmd_entrada/cmd_salida = 1: latch sentido (1 for entrada) and latch medio.
  - Enter FASE1 at edge k+1, so a/b and ocupado change in cycle k+1.
- Phase patterns, written as (a,b):
  - Full entry: FASE1=10, FASE2=11, FASE3=01.
  - Full exit: FASE1=01, FASE2=11, FASE3=10.
  - Half entry (medio=1): 10, 11, 10.
  - Half exit (medio=1): 01, 11, 01.
- Each FASEn lasts exactly PHASE_CYCLES cycles; PAUSA lasts exactly GAP_CYCLES cycles with a=b=0 and ocupado=1.
- Completion: on the cycle after PAUSA ends, state=REPOSO, ocupado=0, fin=1 for that single cycle. A command present in that same cycle is accepted.
- Total latency, command cycle k to fin: fin at cycle k+1+3*PHASE_CYCLES+GAP_CYCLES.
- Glitch-free sensors: a and b never change in the same cycle, except 11->00 which cannot occur in any pattern. There are no 00 cycles inside a sequence.
- Rejection (rechazado=1 for one cycle, no state change):
  - any command while ocupado=1;
  - cmd_entrada and cmd_salida both 1 in REPOSO.
- A held command level therefore produces rechazado every busy cycle. Callers pulse commands.
- medio is ignored except in the acceptance cycle.
- sentido holds its value after fin until the next accepted command.
- Timer: counts 0..N-1 per state and clears on every state transition. There is no wrap-around beyond N-1.

Test Plan (PHASE_CYCLES=4, GAP_CYCLES=2):
- Reset then cmd_entrada=1 for 1 cycle at cycle 0 -> (a,b)=10 cycles 1-4, 11 cycles 5-8, 01 cycles 9-12, 00 cycles 13-14 with ocupado=1; cycle 15 fin=1, ocupado=0, sentido=1. The downstream FSM/counter increments by 1.
- cmd_salida pulse at cycle 0 -> 01 / 11 / 10 over cycles 1-12, fin at cycle 15, sentido=0. The counter decrements by 1.
- cmd_entrada with medio=1 -> 10, 11, 10 over cycles 1-12, fin at 15. The downstream counter is unchanged.
- cmd_salida pulse at cycle 3 during an entry sequence -> rechazado=1 at cycle 3 only; the entry waveform is unaffected. cmd_entrada and cmd_salida together in REPOSO -> rechazado=1, ocupado stays 0.
- cmd_entrada at cycle 15 (the fin cycle) -> accepted; a=1 at cycle 16, no rechazado.
- rst asserted asynchronously mid-FASE2 -> a=b=0 and ocupado=0 before the next clk edge. After release, a new cmd_entrada produces a full correct sequence.
